// File: rtl/upp_frame_monitor.sv
// Receive-side uPP frame checker: hunts SYNC, parses the header, forwards the payload,
// verifies the additive checksum and sequence continuity, and counts good/bad frames.
module upp_frame_monitor #(
    parameter logic [15:0] SYNC_WORD = 16'hA5A5,
    parameter logic [7:0]  MAX_LEN   = 8'd64,
    parameter logic [7:0]  GAP_MAX   = 8'd32
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic [15:0] iDATA,
    input  logic        iENA,
    output logic [15:0] oDATA,
    output logic        oVALID,
    output logic        oSOF,
    output logic        oEOF,
    output logic        oFRAME_OK,
    output logic        oFRAME_ERR,
    output logic [1:0]  oERR_CODE,
    output logic        oSEQ_ERR,
    output logic [15:0] oOK_CNT,
    output logic [15:0] oERR_CNT
);

    typedef enum logic [1:0] {HUNT, HDR, PAYLOAD, CSUM} state_t;

    state_t      state;
    logic [15:0] sum;
    logic [7:0]  seqReg;
    logic [7:0]  lenReg;
    logic [7:0]  remain;
    logic [7:0]  gapCnt;
    logic [7:0]  expSeq;
    logic        seqValid;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state      <= HUNT;
            sum        <= '0;
            seqReg     <= '0;
            lenReg     <= '0;
            remain     <= '0;
            gapCnt     <= '0;
            expSeq     <= '0;
            seqValid   <= 1'b0;
            oDATA      <= '0;
            oVALID     <= 1'b0;
            oSOF       <= 1'b0;
            oEOF       <= 1'b0;
            oFRAME_OK  <= 1'b0;
            oFRAME_ERR <= 1'b0;
            oERR_CODE  <= '0;
            oSEQ_ERR   <= 1'b0;
            oOK_CNT    <= '0;
            oERR_CNT   <= '0;
        end else begin
            oVALID     <= 1'b0;
            oSOF       <= 1'b0;
            oEOF       <= 1'b0;
            oFRAME_OK  <= 1'b0;
            oFRAME_ERR <= 1'b0;
            oSEQ_ERR   <= 1'b0;

            if (state != HUNT && !iENA) gapCnt <= gapCnt + 8'd1;
            else                        gapCnt <= '0;

            // Timeout fires on the idle cycle that would bring the gap count to GAP_MAX.
            if (state != HUNT && !iENA && gapCnt == GAP_MAX - 8'd1) begin
                oFRAME_ERR <= 1'b1;
                oERR_CODE  <= 2'd3;
                if (oERR_CNT != '1) oERR_CNT <= oERR_CNT + 16'd1;
                state <= HUNT;
            end else if (iENA) begin
                case (state)
                    HUNT: begin
                        if (iDATA == SYNC_WORD) state <= HDR;
                    end
                    HDR: begin
                        seqReg <= iDATA[15:8];
                        lenReg <= iDATA[7:0];
                        remain <= iDATA[7:0];
                        sum    <= iDATA;
                        if (iDATA[7:0] > MAX_LEN) begin
                            oFRAME_ERR <= 1'b1;
                            oERR_CODE  <= 2'd1;
                            if (oERR_CNT != '1) oERR_CNT <= oERR_CNT + 16'd1;
                            state <= HUNT;
                        end else if (iDATA[7:0] == 8'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        oDATA  <= iDATA;
                        oVALID <= 1'b1;
                        oSOF   <= (remain == lenReg);
                        oEOF   <= (remain == 8'd1);
                        sum    <= sum + iDATA;
                        remain <= remain - 8'd1;
                        if (remain == 8'd1) state <= CSUM;
                    end
                    CSUM: begin
                        if (iDATA == sum) begin
                            oFRAME_OK <= 1'b1;
                            oERR_CODE <= '0;
                            if (oOK_CNT != '1) oOK_CNT <= oOK_CNT + 16'd1;
                            // The first good frame after reset only establishes the expected sequence.
                            if (seqValid && seqReg != expSeq) oSEQ_ERR <= 1'b1;
                            expSeq   <= seqReg + 8'd1;
                            seqValid <= 1'b1;
                        end else begin
                            oFRAME_ERR <= 1'b1;
                            oERR_CODE  <= 2'd2;
                            if (oERR_CNT != '1) oERR_CNT <= oERR_CNT + 16'd1;
                        end
                        state <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_upp_frame_monitor.sv
// Directed self-checking bench for upp_frame_monitor.
module tb_upp_frame_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] iDATA;
    logic        iENA;
    logic [15:0] oDATA;
    logic        oVALID, oSOF, oEOF, oFRAME_OK, oFRAME_ERR, oSEQ_ERR;
    logic [1:0]  oERR_CODE;
    logic [15:0] oOK_CNT, oERR_CNT;

    int checks = 0;
    int failures = 0;

    upp_frame_monitor #(
        .SYNC_WORD(16'hA5A5),
        .MAX_LEN  (8'd64),
        .GAP_MAX  (8'd32)
    ) dut (
        .iclk      (clk),
        .ireset    (rst),
        .iDATA     (iDATA),
        .iENA      (iENA),
        .oDATA     (oDATA),
        .oVALID    (oVALID),
        .oSOF      (oSOF),
        .oEOF      (oEOF),
        .oFRAME_OK (oFRAME_OK),
        .oFRAME_ERR(oFRAME_ERR),
        .oERR_CODE (oERR_CODE),
        .oSEQ_ERR  (oSEQ_ERR),
        .oOK_CNT   (oOK_CNT),
        .oERR_CNT  (oERR_CNT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one word on the falling edge, then sample 1ns after the accepting edge.
    task automatic step(input logic [15:0] d, input logic e);
        @(negedge clk);
        iDATA = d;
        iENA  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] seq, input logic [7:0] len,
                             input logic [15:0] base, input bit corrupt);
        logic [15:0] sum;
        logic [15:0] w;
        step(16'hA5A5, 1'b1);
        check("sync_novalid", oVALID, 0);
        step({seq, len}, 1'b1);
        check("hdr_novalid", oVALID, 0);
        sum = {seq, len};
        for (int unsigned i = 0; i < len; i++) begin
            w = base + 16'(i);
            step(w, 1'b1);
            sum = sum + w;
            check("pl_valid", oVALID, 1);
            check("pl_data", oDATA, w);
            check("pl_sof", oSOF, (i == 0));
            check("pl_eof", oEOF, (i == len - 1));
        end
        step(corrupt ? sum - 16'd1 : sum, 1'b1);
        check("csum_novalid", oVALID, 0);
    endtask

    initial begin
        rst = 1'b1;
        iDATA = '0;
        iENA = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", oVALID, 0);
        check("rst_okcnt", oOK_CNT, 0);
        check("rst_errcnt", oERR_CNT, 0);
        check("rst_code", oERR_CODE, 0);
        check("rst_pulses", {oFRAME_OK, oFRAME_ERR, oSEQ_ERR}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Good frame A5A5,0003,1,2,3,0009
        sendFrame(8'h00, 8'd3, 16'h0001, 1'b0);
        check("f1_ok", oFRAME_OK, 1);
        check("f1_err", oFRAME_ERR, 0);
        check("f1_seq", oSEQ_ERR, 0);
        check("f1_okcnt", oOK_CNT, 1);
        step(16'h0000, 1'b0);
        check("f1_pulse_once", oFRAME_OK, 0);

        // Same frame, checksum 0008
        sendFrame(8'h00, 8'd3, 16'h0001, 1'b1);
        check("bad_err", oFRAME_ERR, 1);
        check("bad_ok", oFRAME_OK, 0);
        check("bad_code", oERR_CODE, 2);
        check("bad_errcnt", oERR_CNT, 1);
        check("bad_okcnt", oOK_CNT, 1);

        // Oversized header, len 65
        step(16'hA5A5, 1'b1);
        step(16'h0041, 1'b1);
        check("len_err", oFRAME_ERR, 1);
        check("len_code", oERR_CODE, 1);
        check("len_valid", oVALID, 0);
        check("len_errcnt", oERR_CNT, 2);
        step(16'h1234, 1'b1);
        check("len_hunt_novalid", oVALID, 0);

        // Sequence continuity: expected is 1 after the first good frame
        sendFrame(8'h01, 8'd1, 16'h00AA, 1'b0);
        check("s1_ok", oFRAME_OK, 1);
        check("s1_seq", oSEQ_ERR, 0);
        sendFrame(8'h05, 8'd2, 16'h0010, 1'b0);
        check("s5_ok", oFRAME_OK, 1);
        check("s5_seq", oSEQ_ERR, 1);
        sendFrame(8'h07, 8'd1, 16'hFFFF, 1'b0);
        check("s7_ok", oFRAME_OK, 1);
        check("s7_seq", oSEQ_ERR, 1);
        sendFrame(8'h08, 8'd4, 16'h8000, 1'b0);
        check("s8_ok", oFRAME_OK, 1);
        check("s8_seq", oSEQ_ERR, 0);
        check("s8_okcnt", oOK_CNT, 5);

        // 32-cycle gap mid-payload aborts with code 3
        step(16'hA5A5, 1'b1);
        step(16'h0903, 1'b1);
        step(16'h0001, 1'b1);
        check("g32_first", oVALID, 1);
        for (int i = 0; i < 31; i++) step(16'h0000, 1'b0);
        check("g32_not_yet", oFRAME_ERR, 0);
        step(16'h0000, 1'b0);
        check("g32_err", oFRAME_ERR, 1);
        check("g32_code", oERR_CODE, 3);
        check("g32_eof", oEOF, 0);
        check("g32_errcnt", oERR_CNT, 3);
        step(16'h0002, 1'b1);
        check("g32_hunt_novalid", oVALID, 0);

        // 31-cycle gap survives; errored seq 09 left expected at 09, so seq 0A flags
        step(16'hA5A5, 1'b1);
        step(16'h0A02, 1'b1);
        step(16'h0001, 1'b1);
        check("g31_sof", oSOF, 1);
        for (int i = 0; i < 31; i++) step(16'h0000, 1'b0);
        check("g31_noerr", oFRAME_ERR, 0);
        step(16'h0002, 1'b1);
        check("g31_data", oDATA, 16'h0002);
        check("g31_eof", oEOF, 1);
        step(16'h0A05, 1'b1);
        check("g31_ok", oFRAME_OK, 1);
        check("g31_seq", oSEQ_ERR, 1);
        check("g31_okcnt", oOK_CNT, 6);

        // Reset mid-payload
        step(16'hA5A5, 1'b1);
        step(16'h0B03, 1'b1);
        step(16'h0001, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        iDATA = 16'h0002;
        iENA = 1'b1;
        @(posedge clk);
        #1;
        check("mr_valid", oVALID, 0);
        check("mr_data", oDATA, 0);
        check("mr_pulses", {oFRAME_OK, oFRAME_ERR, oSEQ_ERR}, 0);
        check("mr_okcnt", oOK_CNT, 0);
        check("mr_errcnt", oERR_CNT, 0);
        @(negedge clk);
        rst = 1'b0;
        iENA = 1'b0;

        // Zero-length frame A5A5,0100,0100
        step(16'hA5A5, 1'b1);
        step(16'h0100, 1'b1);
        check("z_hdr_novalid", oVALID, 0);
        step(16'h0100, 1'b1);
        check("z_ok", oFRAME_OK, 1);
        check("z_novalid", oVALID, 0);
        check("z_seq", oSEQ_ERR, 0);
        check("z_okcnt", oOK_CNT, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/upp_frame_monitor.md
Name: upp_frame_monitor

Overview:
Receive-side checker on the uPP word stream produced by the BLVDS-to-uPP bridge (16-bit data plus ENA qualifier). Hunts for a sync word, parses header, forwards payload words with frame markers, verifies a 16-bit additive checksum and sequence continuity, and keeps saturating good/bad frame counters. Used in the simulation top and on hardware as a bring-up and link-integrity monitor between the bridge and the DSP-facing uPP pins.

Parameters:
SYNC_WORD, 16'hA5A5, frame start marker
MAX_LEN, 8'd64, largest legal payload length in words
GAP_MAX, 8'd32, idle cycles (iENA=0) tolerated inside a frame before timeout

Ports:
iclk  input  1  single clock; all logic on rising edge
ireset  input  1  synchronous active-high reset
iDATA  input  16  uPP data word
iENA  input  1  word qualifier; word accepted on every cycle iENA=1
oDATA  output  16  forwarded payload word
oVALID  output  1  oDATA valid
oSOF  output  1  with first payload word
oEOF  output  1  with last payload word
oFRAME_OK  output  1  one-cycle pulse: frame closed with correct checksum
oFRAME_ERR  output  1  one-cycle pulse: frame aborted or bad checksum
oERR_CODE  output  2  1=length>MAX_LEN, 2=checksum, 3=gap timeout; held until next result
oSEQ_ERR  output  1  pulse alongside oFRAME_OK when seq != expected
oOK_CNT  output  16  good frames, saturates at 16'hFFFF
oERR_CNT  output  16  bad frames, saturates at 16'hFFFF

Behaviour:
- Frame: word0=SYNC_WORD; word1=header {seq[15:8], len[7:0]}; len payload words; then checksum word = (header + sum of payload) mod 2^16. SYNC not included in checksum.
- Reset (ireset=1 on clock edge): all outputs 0, oERR_CODE=0, counters 0, state HUNT, sequence-expected flag cleared. Reset mid-frame drops the frame silently (no pulse, no count).
- FSM: HUNT -> HDR on accepted word == SYNC_WORD; other words ignored. HDR on accepted word: latch seq/len, running sum = header; len>MAX_LEN -> error code 1, HUNT; len==0 -> CSUM; else PAYLOAD. PAYLOAD: each accepted word forwarded, added to sum, word counter decremented; after len-th word -> CSUM. CSUM on accepted word: compare with sum -> OK or ERR(code 2) -> HUNT.
- Payload inside frame is not scanned for SYNC_WORD; no resync until frame ends.
- Payload latency: oDATA/oVALID registered, one cycle after the accepted iDATA. oSOF/oEOF coincide with oVALID; len==1 gives oSOF=oEOF=1 same cycle. len==0 emits no payload.
- Result latency: oFRAME_OK/oFRAME_ERR pulse one cycle after the accepting edge of the checksum word (or the bad header / timeout edge). Exactly one of the two per frame leaving HDR/PAYLOAD/CSUM.
- Gap timeout: in HDR/PAYLOAD/CSUM, counter increments each iENA=0 cycle, clears on iENA=1. Reaching GAP_MAX -> oFRAME_ERR, code 3, HUNT. Partial payload already forwarded; no oEOF issued for aborted frame.
- Sequence: first OK frame after reset only loads expected = seq+1 (mod 256). Later OK frames: seq != expected -> oSEQ_ERR pulse; expected always reloaded to seq+1. Errored frames do not touch expected.
- Counters: +1 on each OK / ERR pulse, hold at 16'hFFFF. oSEQ_ERR does not change oERR_CNT.
- iENA=0 cycles in HUNT have no effect.

Test Plan:
- Good frame A5A5,0003,0001,0002,0003,0009 back-to-back iENA=1 -> oVALID 3 cycles with data 1,2,3, oSOF on first, oEOF on third, oFRAME_OK one cycle after 0009 edge, oOK_CNT=1.
- Same frame, checksum 0008 -> oFRAME_ERR, oERR_CODE=2, oERR_CNT=1, oOK_CNT unchanged.
- Header 0041 (len 65) -> immediate oFRAME_ERR code 1, no oVALID; next valid frame accepted normally.
- Good frame seq 05 then good frame seq 07 -> second oFRAME_OK with oSEQ_ERR=1; third frame seq 08 -> no oSEQ_ERR.
- Payload interrupted with iENA=0 for 32 cycles -> oFRAME_ERR code 3 on 32nd idle cycle's following cycle, state HUNT; 31-cycle gap -> frame completes OK.
- ireset asserted mid-payload -> all outputs 0 next cycle, counters 0, no pulse; len==0 frame A5A5,0100,0100 -> oFRAME_OK, no oVALID.
